// File: rtl/risc_param_reg_file.sv
// Parametrised 2R/1W register file with sequential init fill and optional WB->read forwarding.
// Reads register one cycle after the address edge; WB writes arriving while busy are dropped and flagged on wr_drop.
module risc_param_reg_file #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] DOF_EX_AA,
  input  logic [ADDR_W-1:0] DOF_EX_BA,
  input  logic [ADDR_W-1:0] WB_DA,
  input  logic              WB_RW,
  input  logic [DATA_W-1:0] WB_Bus_D,
  input  logic              init_req,
  output logic [DATA_W-1:0] Reg_Bus_A,
  output logic [DATA_W-1:0] Reg_Bus_B,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   idx_nxt;
  logic [DATA_W-1:0]   init_val;
  logic [DATA_W-1:0]   rd_a;
  logic [DATA_W-1:0]   rd_b;
  logic                drop_nxt;
  logic                wr_run;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Writes to the hardwired zero entry are silently ignored, not counted as drops.
  assign wr_run = (state == ST_RUN) && WB_RW && !((ZERO_REG != 0) && (WB_DA == '0));
  assign busy   = (state == ST_INIT);

  always_comb begin
    init_val = '0;
    if (INIT_MODE != 0) begin
      init_val[ADDR_W-1:0] = idx;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if ((ZERO_REG != 0) && (ra == '0)) begin
      val = '0;
    end else if ((BYPASS != 0) && wr_run && (WB_DA == ra)) begin
      val = WB_Bus_D;
    end
    return val;
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rd_a      = '0;
    rd_b      = '0;
    drop_nxt  = 1'b0;
    unique case (state)
      ST_INIT: begin
        idx_nxt  = idx + 1'b1;
        drop_nxt = WB_RW;
        if (idx == LAST_IDX) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        rd_a = read_port(DOF_EX_AA, mem[DOF_EX_AA]);
        rd_b = read_port(DOF_EX_BA, mem[DOF_EX_BA]);
        if (init_req) begin
          state_nxt = ST_INIT;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      idx       <= '0;
      Reg_Bus_A <= '0;
      Reg_Bus_B <= '0;
      wr_drop   <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      Reg_Bus_A <= rd_a;
      Reg_Bus_B <= rd_b;
      wr_drop   <= drop_nxt;
    end
  end

  // Array has no reset; while reset is held the engine only rewrites entry 0 with its init value.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[idx] <= init_val;
    end else if (wr_run) begin
      mem[WB_DA] <= WB_Bus_D;
    end
  end

endmodule

// File: tb/tb_risc_param_reg_file.sv
// Drives a default 32x32 instance and a small 8x8 variant (no zero reg, no bypass, zero fill) from shared stimulus.
module tb_risc_param_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  aa, ba, da;
  logic        rw, ir;
  logic [31:0] wd;
  logic [31:0] a0, b0;
  logic        busy0, drop0;
  logic [7:0]  a1, b1;
  logic        busy1, drop1;

  always #5 clk = ~clk;

  risc_param_reg_file u_dut (
    .clk(clk), .reset(reset), .DOF_EX_AA(aa), .DOF_EX_BA(ba), .WB_DA(da), .WB_RW(rw),
    .WB_Bus_D(wd), .init_req(ir), .Reg_Bus_A(a0), .Reg_Bus_B(b0), .busy(busy0), .wr_drop(drop0)
  );

  risc_param_reg_file #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0), .INIT_MODE(0)) u_alt (
    .clk(clk), .reset(reset), .DOF_EX_AA(aa[2:0]), .DOF_EX_BA(ba[2:0]), .WB_DA(da[2:0]), .WB_RW(rw),
    .WB_Bus_D(wd[7:0]), .init_req(ir), .Reg_Bus_A(a1), .Reg_Bus_B(b1), .busy(busy1), .wr_drop(drop1)
  );

  typedef struct {
    logic [31:0] a0, b0, a1, b1;
    logic        busy0, drop0, busy1, drop1;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_mem [2][32];
  int          m_st  [2];
  int          m_idx [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k]  = 0;
      m_idx[k] = 0;
    end
  endtask

  function automatic logic [31:0] mrd(input int k, input int x, input int d, input logic [31:0] w,
                                      input logic wr);
    if (k == 0 && x == 0) return 32'h0;
    if (k == 0 && wr && d == x) return w;
    return m_mem[k][x];
  endfunction

  // Instance 0: zero reg, bypass, index fill. Instance 1: none of those.
  task automatic model_step(input int k, output logic [31:0] ea, output logic [31:0] eb,
                            output logic eby, output logic edr);
    int          depth, a, b, d;
    logic [31:0] w;
    logic        wr;
    depth = (k == 0) ? 32 : 8;
    a = int'(aa) % depth;
    b = int'(ba) % depth;
    d = int'(da) % depth;
    w = (k == 0) ? wd : (wd & 32'hFF);
    if (m_st[k] == 0) begin
      ea = 0;
      eb = 0;
      edr = rw;
      m_mem[k][m_idx[k]] = (k == 0) ? 32'(m_idx[k]) : 32'h0;
      if (m_idx[k] == depth - 1) m_st[k] = 1;
      m_idx[k] = (m_idx[k] + 1) % depth;
    end else begin
      wr  = rw && !(k == 0 && d == 0);
      ea  = mrd(k, a, d, w, wr);
      eb  = mrd(k, b, d, w, wr);
      edr = 1'b0;
      if (wr) m_mem[k][d] = w;
      if (ir) begin
        m_st[k]  = 0;
        m_idx[k] = 0;
      end
    end
    eby = (m_st[k] == 0);
  endtask

  task automatic cycle(input logic [4:0] a_i, input logic [4:0] b_i, input logic [4:0] d_i,
                       input logic rw_i, input logic [31:0] w_i, input logic ir_i);
    exp_t        e, g;
    logic [31:0] xa, xb;
    logic        xby, xdr;
    aa = a_i; ba = b_i; da = d_i; rw = rw_i; wd = w_i; ir = ir_i;
    model_step(0, xa, xb, xby, xdr);
    e.a0 = xa; e.b0 = xb; e.busy0 = xby; e.drop0 = xdr;
    model_step(1, xa, xb, xby, xdr);
    e.a1 = xa; e.b1 = xb; e.busy1 = xby; e.drop1 = xdr;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk("bus_a", a0, g.a0);
    chk("bus_b", b0, g.b0);
    chk("busy", 32'(busy0), 32'(g.busy0));
    chk("wr_drop", 32'(drop0), 32'(g.drop0));
    chk("alt_bus_a", 32'(a1), g.a1);
    chk("alt_bus_b", 32'(b1), g.b1);
    chk("alt_busy", 32'(busy1), 32'(g.busy1));
    chk("alt_wr_drop", 32'(drop1), 32'(g.drop1));
  endtask

  task automatic idle();
    cycle(5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_a"}, a0, 32'h0);
    chk({tag, "_b"}, b0, 32'h0);
    chk({tag, "_busy"}, 32'(busy0), 32'h1);
    chk({tag, "_drop"}, 32'(drop0), 32'h0);
    chk({tag, "_alt_a"}, 32'(a1), 32'h0);
    chk({tag, "_alt_busy"}, 32'(busy1), 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b0;
    aa = 0; ba = 0; da = 0; rw = 0; wd = 0; ir = 0;
    model_reset();
    #1 rst_check("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    cnt = 0;
    while (busy0 && cnt < 40) begin
      idle();
      cnt++;
    end
    chk("init_len", 32'(cnt), 32'd32);
    cycle(5'd5, 5'd31, 5'd0, 1'b0, 32'h0, 1'b0);
    chk("t1_a", a0, 32'd5);
    chk("t1_b", b0, 32'd31);

    cycle(5'd7, 5'd0, 5'd7, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("t2_bypass", a0, 32'hDEADBEEF);
    chk("t2_alt_old", 32'(a1), 32'h0);
    cycle(5'd7, 5'd7, 5'd0, 1'b0, 32'h0, 1'b0);
    chk("t2_alt_new", 32'(a1), 32'hEF);
    chk("t2_b", b0, 32'hDEADBEEF);

    cycle(5'd0, 5'd0, 5'd0, 1'b1, 32'h12345678, 1'b0);
    chk("t3_zero_same", a0, 32'h0);
    idle();
    chk("t3_zero_later", a0, 32'h0);
    chk("t3_alt_r0", 32'(a1), 32'h78);

    cycle(5'd0, 5'd0, 5'd3, 1'b1, 32'hAAAA0000, 1'b0);
    cycle(5'd3, 5'd3, 5'd0, 1'b0, 32'h0, 1'b0);
    chk("t4_pre", a0, 32'hAAAA0000);
    cycle(5'd3, 5'd0, 5'd9, 1'b1, 32'h55, 1'b1);
    chk("t4_req_rd", a0, 32'hAAAA0000);
    cnt = 0;
    while (busy0 && cnt < 40) begin
      cycle(5'd3, 5'd3, 5'd12, (cnt == 4), 32'h77, 1'b0);
      chk("t4_zero_a", a0, 32'h0);
      if (cnt == 4) chk("t4_drop", 32'(drop0), 32'h1);
      cnt++;
    end
    chk("t4_len", 32'(cnt), 32'd32);
    cycle(5'd3, 5'd9, 5'd0, 1'b0, 32'h0, 1'b0);
    chk("t4_post_a", a0, 32'd3);
    chk("t4_post_b", b0, 32'd9);

    for (int i = 0; i < 200; i++) begin
      cycle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 39) == 0));
    end
    cnt = 0;
    while (busy0 && cnt < 40) begin
      idle();
      cnt++;
    end

    cycle(5'd5, 5'd6, 5'd0, 1'b0, 32'h0, 1'b0);
    chk("t5_run_nz", a0, 32'd5);
    reset = 1'b0;
    model_reset();
    #1 rst_check("rst_run");
    @(posedge clk);
    #1 rst_check("rst_hold");
    reset = 1'b1;
    repeat (10) idle();
    reset = 1'b0;
    model_reset();
    #1 rst_check("rst_init");
    @(posedge clk);
    #1 reset = 1'b1;
    cnt = 0;
    while (busy0 && cnt < 40) begin
      idle();
      cnt++;
    end
    chk("t5_len", 32'(cnt), 32'd32);
    cycle(5'd20, 5'd20, 5'd0, 1'b0, 32'h0, 1'b0);
    chk("t5_e20", a0, 32'd20);

    cycle(5'd0, 5'd0, 5'd7, 1'b1, 32'hFF, 1'b0);
    cycle(5'd7, 5'd7, 5'd0, 1'b0, 32'h0, 1'b0);
    chk("t6_alt_e7", 32'(a1), 32'hFF);
    chk("t6_e7", a0, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
